// File: rtl/vend_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vend_pkg                                                      |
// | Purpose  : Shared types and coin values for the soda vending sequencer.  |
// |            All money is expressed in nickel units.                       |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package vend_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      COLLECT = 3'd1,
      VEND    = 3'd2,
      CHANGE  = 3'd3,
      FAULT   = 3'd4
   } state_t;

   localparam logic [2:0] NICKEL_V  = 3'd1;
   localparam logic [2:0] DIME_V    = 3'd2;
   localparam logic [2:0] QUARTER_V = 3'd5;

endpackage
`default_nettype wire

// File: rtl/coin_value_dec.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : coin_value_dec                                                |
// | Purpose  : Decodes the three coin strobes into a credit value in nickels.|
// |            Any combination of more than one coin is worth nothing and is |
// |            flagged so the sequencer can bounce it to the return chute.   |
// | Ports    : nickle, dime, quarter  in   coin strobes                      |
// |            value[2:0]             out  coin value in nickels             |
// |            multi_hot              out  more than one strobe high         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module coin_value_dec
   import vend_pkg::*;
(
   input  logic       nickle,
   input  logic       dime,
   input  logic       quarter,
   output logic [2:0] value,
   output logic       multi_hot
);

   always_comb begin
      value     = 3'd0;
      multi_hot = 1'b0;
      case ({quarter, dime, nickle})
         3'b000:  value     = 3'd0;
         3'b001:  value     = NICKEL_V;
         3'b010:  value     = DIME_V;
         3'b100:  value     = QUARTER_V;
         default: multi_hot = 1'b1;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/vend_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vend_sequencer                                                |
// | Purpose  : Control sequencer for the soda vending datapath. Accumulates  |
// |            coin credit, requests a dispense once credit reaches PRICE,   |
// |            then pays change out one nickel at a time. Supports cancel/   |
// |            refund and faults if a request waits too long for its ack.    |
// | Ports    : clk_i, reset_n            clock, async active-low reset       |
// |            nickle_i/dime_i/quarter_i coin strobes (1-cycle pulses)       |
// |            cancel_i                  refund request pulse                |
// |            vend_ack_i, coin_ack_i    dispenser / hopper acknowledges     |
// |            soda_req_o, coin_req_o    level requests (registered)         |
// |            coin_reject_o             same-cycle reject of incoming coin  |
// |            credit_o                  credit or remaining change          |
// |            busy_o, fault_o           status (registered)                 |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module vend_sequencer
   import vend_pkg::*;
#(
   parameter int PRICE    = 4,
   parameter int CREDIT_W = 4,
   parameter int ACK_TMO  = 64,
   parameter int TMO_W    = 7
)(
   input  logic                clk_i,
   input  logic                reset_n,
   input  logic                nickle_i,
   input  logic                dime_i,
   input  logic                quarter_i,
   input  logic                cancel_i,
   input  logic                vend_ack_i,
   input  logic                coin_ack_i,
   output logic                soda_req_o,
   output logic                coin_req_o,
   output logic                coin_reject_o,
   output logic [CREDIT_W-1:0] credit_o,
   output logic                busy_o,
   output logic                fault_o
);

   localparam logic [CREDIT_W-1:0] c_price      = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W-1:0] c_max_credit = CREDIT_W'(PRICE + 4);
   localparam logic [CREDIT_W-1:0] c_one        = CREDIT_W'(1);
   localparam logic [TMO_W-1:0]    c_tmo_last   = TMO_W'(ACK_TMO - 1);
   localparam logic [TMO_W-1:0]    c_tmo_one    = TMO_W'(1);

   state_t              r_state;
   state_t              w_next_state;
   logic [CREDIT_W-1:0] r_credit;
   logic [CREDIT_W-1:0] w_next_credit;
   logic [CREDIT_W-1:0] w_after_vend;
   logic [TMO_W-1:0]    r_timer;
   logic [TMO_W-1:0]    w_next_timer;
   logic                r_soda_req;
   logic                r_coin_req;
   logic                r_busy;
   logic                r_fault;

   logic [2:0]          w_coin_value;
   logic                w_multi_hot;
   logic                w_any_coin;
   logic                w_open;
   logic                w_cancel_refund;
   logic                w_vend_trigger;
   logic                w_accept;
   logic                w_ack;

   coin_value_dec u_coin_value_dec (
      .nickle    (nickle_i),
      .dime      (dime_i),
      .quarter   (quarter_i),
      .value     (w_coin_value),
      .multi_hot (w_multi_hot)
   );

   // Coins are only credited while collecting and only when neither a refund
   // nor a dispense is being launched this cycle; everything else bounces.
   assign w_any_coin      = nickle_i | dime_i | quarter_i;
   assign w_open          = (r_state == IDLE) || (r_state == COLLECT);
   assign w_cancel_refund = w_open && cancel_i && (r_credit != '0);
   assign w_vend_trigger  = (r_state == COLLECT) && (r_credit >= c_price);
   assign w_accept        = w_open && !w_cancel_refund && !w_vend_trigger
                            && !w_multi_hot && w_any_coin;
   assign coin_reject_o   = w_any_coin && !w_accept;

   // Only acks that answer the current request count; stray ones are ignored.
   assign w_ack        = ((r_state == VEND) && vend_ack_i) ||
                         ((r_state == CHANGE) && coin_ack_i);
   assign w_after_vend = r_credit - c_price;

   always_comb begin
      w_next_state  = r_state;
      w_next_credit = r_credit;
      case (r_state)
         IDLE, COLLECT: begin
            if (w_cancel_refund) begin
               w_next_state = CHANGE;
            end else if (w_vend_trigger) begin
               w_next_state = VEND;
            end else if (w_accept) begin
               w_next_state  = COLLECT;
               w_next_credit = r_credit + CREDIT_W'(w_coin_value);
            end
         end
         VEND: begin
            if (vend_ack_i) begin
               w_next_credit = w_after_vend;
               w_next_state  = (w_after_vend != '0) ? CHANGE : IDLE;
            end else if (r_timer == c_tmo_last) begin
               w_next_state = FAULT;
            end
         end
         CHANGE: begin
            if (coin_ack_i && (r_credit != '0)) begin
               w_next_credit = r_credit - c_one;
               if (r_credit == c_one) begin
                  w_next_state = IDLE;
               end
            end else if (r_timer == c_tmo_last) begin
               w_next_state = FAULT;
            end
         end
         FAULT: begin
            w_next_state = FAULT;
         end
         default: begin
            w_next_state  = IDLE;
            w_next_credit = '0;
         end
      endcase
   end

   // The timer restarts on every state change and every accepted ack, so the
   // bound applies to each individual request rather than the whole payout.
   always_comb begin
      w_next_timer = '0;
      if ((w_next_state == r_state) && !w_ack &&
          ((r_state == VEND) || (r_state == CHANGE))) begin
         w_next_timer = r_timer + c_tmo_one;
      end
   end

   // Outputs are registered from next-state values so they line up with the
   // state they describe and carry no combinational path from the inputs.
   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_credit   <= '0;
         r_timer    <= '0;
         r_soda_req <= 1'b0;
         r_coin_req <= 1'b0;
         r_busy     <= 1'b0;
         r_fault    <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_credit   <= w_next_credit;
         r_timer    <= w_next_timer;
         r_soda_req <= (w_next_state == VEND);
         r_coin_req <= (w_next_state == CHANGE) && (w_next_credit != '0);
         r_busy     <= (w_next_state == VEND) || (w_next_state == CHANGE) ||
                       (w_next_state == FAULT);
         r_fault    <= (w_next_state == FAULT);
      end
   end

   assign soda_req_o = r_soda_req;
   assign coin_req_o = r_coin_req;
   assign busy_o     = r_busy;
   assign fault_o    = r_fault;
   assign credit_o   = r_credit;

   // Coins are only added below PRICE, so credit is bounded by PRICE+4.
   a_credit_bound: assert property (@(posedge clk_i) disable iff (!reset_n)
                                    r_credit <= c_max_credit);

endmodule
`default_nettype wire

// File: tb/tb_vend_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_vend_sequencer                                             |
// | Purpose  : Directed self-checking bench for vend_sequencer.              |
// |            obs = {soda_req, coin_req, busy, fault, credit[3:0]}          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_vend_sequencer;

   logic       clk_i      = 1'b0;
   logic       reset_n    = 1'b0;
   logic       nickle_i   = 1'b0;
   logic       dime_i     = 1'b0;
   logic       quarter_i  = 1'b0;
   logic       cancel_i   = 1'b0;
   logic       vend_ack_i = 1'b0;
   logic       coin_ack_i = 1'b0;
   logic       soda_req_o;
   logic       coin_req_o;
   logic       coin_reject_o;
   logic [3:0] credit_o;
   logic       busy_o;
   logic       fault_o;

   int         errors = 0;
   int         checks = 0;
   logic       seen_soda = 1'b0;
   logic       seen_coin = 1'b0;
   logic [7:0] exp_obs;

   wire [7:0] obs = {soda_req_o, coin_req_o, busy_o, fault_o, credit_o};

   vend_sequencer #(
      .PRICE    (4),
      .CREDIT_W (4),
      .ACK_TMO  (64),
      .TMO_W    (7)
   ) dut (
      .clk_i         (clk_i),
      .reset_n       (reset_n),
      .nickle_i      (nickle_i),
      .dime_i        (dime_i),
      .quarter_i     (quarter_i),
      .cancel_i      (cancel_i),
      .vend_ack_i    (vend_ack_i),
      .coin_ack_i    (coin_ack_i),
      .soda_req_o    (soda_req_o),
      .coin_req_o    (coin_req_o),
      .coin_reject_o (coin_reject_o),
      .credit_o      (credit_o),
      .busy_o        (busy_o),
      .fault_o       (fault_o)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) begin
      if (soda_req_o) seen_soda = 1'b1;
      if (coin_req_o) seen_coin = 1'b1;
   end

   // Advance one clock; inputs applied before the call are seen on that edge.
   task automatic step();
      @(posedge clk_i);
      #1;
      nickle_i   = 1'b0;
      dime_i     = 1'b0;
      quarter_i  = 1'b0;
      cancel_i   = 1'b0;
      vend_ack_i = 1'b0;
      coin_ack_i = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      checks++; if (obs !== 8'b0000_0000) begin errors++; $display("FAIL reset_hold: obs=%b expected=%b", obs, 8'b0000_0000); end
      checks++; if (coin_reject_o !== 1'b0) begin errors++; $display("FAIL reset_reject: got=%b expected=0", coin_reject_o); end
      @(negedge clk_i);
      reset_n = 1'b1;
      step();
      checks++; if (obs !== 8'b0000_0000) begin errors++; $display("FAIL reset_release: obs=%b expected=%b", obs, 8'b0000_0000); end
   endtask

   task automatic test_exact_price();
      seen_coin = 1'b0;
      nickle_i = 1'b1; #1;
      checks++; if (coin_reject_o !== 1'b0) begin errors++; $display("FAIL exact_n_reject: got=%b expected=0", coin_reject_o); end
      step();
      checks++; if (obs !== 8'b0000_0001) begin errors++; $display("FAIL exact_n: obs=%b expected=%b", obs, 8'b0000_0001); end
      dime_i = 1'b1; step();
      nickle_i = 1'b1; step();
      checks++; if (obs !== 8'b0000_0100) begin errors++; $display("FAIL exact_ndn: obs=%b expected=%b", obs, 8'b0000_0100); end
      step();
      checks++; if (obs !== 8'b1010_0100) begin errors++; $display("FAIL exact_vend: obs=%b expected=%b", obs, 8'b1010_0100); end
      step();
      vend_ack_i = 1'b1; step();
      checks++; if (obs !== 8'b0000_0000) begin errors++; $display("FAIL exact_ack: obs=%b expected=%b", obs, 8'b0000_0000); end
      checks++; if (seen_coin !== 1'b0) begin errors++; $display("FAIL exact_no_change: coin_req seen=%b expected=0", seen_coin); end
   endtask

   task automatic test_overpay();
      dime_i = 1'b1; step();
      dime_i = 1'b1; step();
      step();
      checks++; if (obs !== 8'b1010_0100) begin errors++; $display("FAIL over_dd_vend: obs=%b expected=%b", obs, 8'b1010_0100); end
      cancel_i = 1'b1; step();
      step();
      checks++; if (obs !== 8'b1010_0100) begin errors++; $display("FAIL over_vend_hold: obs=%b expected=%b", obs, 8'b1010_0100); end
      vend_ack_i = 1'b1; step();
      checks++; if (obs !== 8'b0000_0000) begin errors++; $display("FAIL over_dd_ack: obs=%b expected=%b", obs, 8'b0000_0000); end
      quarter_i = 1'b1; step();
      checks++; if (obs !== 8'b0000_0101) begin errors++; $display("FAIL over_q: obs=%b expected=%b", obs, 8'b0000_0101); end
      quarter_i = 1'b1; #1;
      checks++; if (coin_reject_o !== 1'b1) begin errors++; $display("FAIL over_qq_reject: got=%b expected=1", coin_reject_o); end
      step();
      checks++; if (obs !== 8'b1010_0101) begin errors++; $display("FAIL over_qq_vend: obs=%b expected=%b", obs, 8'b1010_0101); end
      quarter_i = 1'b1; #1;
      checks++; if (coin_reject_o !== 1'b1) begin errors++; $display("FAIL over_vend_reject: got=%b expected=1", coin_reject_o); end
      step();
      vend_ack_i = 1'b1; step();
      checks++; if (obs !== 8'b0110_0001) begin errors++; $display("FAIL over_change: obs=%b expected=%b", obs, 8'b0110_0001); end
      coin_ack_i = 1'b1; step();
      checks++; if (obs !== 8'b0000_0000) begin errors++; $display("FAIL over_change_done: obs=%b expected=%b", obs, 8'b0000_0000); end
   endtask

   task automatic test_refund();
      seen_soda = 1'b0;
      nickle_i = 1'b1; step();
      dime_i = 1'b1; step();
      checks++; if (obs !== 8'b0000_0011) begin errors++; $display("FAIL refund_credit: obs=%b expected=%b", obs, 8'b0000_0011); end
      cancel_i = 1'b1; step();
      checks++; if (obs !== 8'b0110_0011) begin errors++; $display("FAIL refund_enter: obs=%b expected=%b", obs, 8'b0110_0011); end
      step();
      checks++; if (obs !== 8'b0110_0011) begin errors++; $display("FAIL refund_hold: obs=%b expected=%b", obs, 8'b0110_0011); end
      coin_ack_i = 1'b1; step();
      coin_ack_i = 1'b1; step();
      checks++; if (obs !== 8'b0110_0001) begin errors++; $display("FAIL refund_two: obs=%b expected=%b", obs, 8'b0110_0001); end
      coin_ack_i = 1'b1; step();
      checks++; if (obs !== 8'b0000_0000) begin errors++; $display("FAIL refund_done: obs=%b expected=%b", obs, 8'b0000_0000); end
      checks++; if (seen_soda !== 1'b0) begin errors++; $display("FAIL refund_no_soda: soda_req seen=%b expected=0", seen_soda); end
   endtask

   task automatic test_simultaneous();
      dime_i = 1'b1; quarter_i = 1'b1; #1;
      checks++; if (coin_reject_o !== 1'b1) begin errors++; $display("FAIL multi_reject: got=%b expected=1", coin_reject_o); end
      step();
      checks++; if (obs !== 8'b0000_0000) begin errors++; $display("FAIL multi_credit: obs=%b expected=%b", obs, 8'b0000_0000); end
      nickle_i = 1'b1; cancel_i = 1'b1; #1;
      checks++; if (coin_reject_o !== 1'b0) begin errors++; $display("FAIL cancel0_reject: got=%b expected=0", coin_reject_o); end
      step();
      nickle_i = 1'b1; step();
      vend_ack_i = 1'b1; coin_ack_i = 1'b1; step();
      checks++; if (obs !== 8'b0000_0010) begin errors++; $display("FAIL stray_ack: obs=%b expected=%b", obs, 8'b0000_0010); end
      nickle_i = 1'b1; cancel_i = 1'b1; #1;
      checks++; if (coin_reject_o !== 1'b1) begin errors++; $display("FAIL cancel_coin_reject: got=%b expected=1", coin_reject_o); end
      step();
      checks++; if (obs !== 8'b0110_0010) begin errors++; $display("FAIL cancel_coin_refund: obs=%b expected=%b", obs, 8'b0110_0010); end
      coin_ack_i = 1'b1; step();
      coin_ack_i = 1'b1; step();
      checks++; if (obs !== 8'b0000_0000) begin errors++; $display("FAIL cancel_coin_done: obs=%b expected=%b", obs, 8'b0000_0000); end
   endtask

   task automatic test_timeout();
      nickle_i = 1'b1; step();
      dime_i = 1'b1; step();
      nickle_i = 1'b1; step();
      step();
      for (int i = 0; i < 63; i++) step();
      checks++; if (obs !== 8'b1010_0100) begin errors++; $display("FAIL tmo_last_vend: obs=%b expected=%b", obs, 8'b1010_0100); end
      step();
      checks++; if (obs !== 8'b0011_0100) begin errors++; $display("FAIL tmo_fault: obs=%b expected=%b", obs, 8'b0011_0100); end
      nickle_i = 1'b1; #1;
      checks++; if (coin_reject_o !== 1'b1) begin errors++; $display("FAIL fault_reject: got=%b expected=1", coin_reject_o); end
      step();
      vend_ack_i = 1'b1; step();
      checks++; if (obs !== 8'b0011_0100) begin errors++; $display("FAIL fault_sticky: obs=%b expected=%b", obs, 8'b0011_0100); end
      @(negedge clk_i);
      reset_n = 1'b0; #1;
      checks++; if (obs !== 8'b0000_0000) begin errors++; $display("FAIL fault_reset: obs=%b expected=%b", obs, 8'b0000_0000); end
      @(negedge clk_i);
      reset_n = 1'b1;
      nickle_i = 1'b1; step();
      checks++; if (obs !== 8'b0000_0001) begin errors++; $display("FAIL fault_recover: obs=%b expected=%b", obs, 8'b0000_0001); end
      cancel_i = 1'b1; step();
      coin_ack_i = 1'b1; step();
   endtask

   task automatic test_reset_mid_payout();
      nickle_i = 1'b1; step();
      dime_i = 1'b1; step();
      cancel_i = 1'b1; step();
      checks++; if (obs !== 8'b0110_0011) begin errors++; $display("FAIL mid_change: obs=%b expected=%b", obs, 8'b0110_0011); end
      #2;
      reset_n = 1'b0; #1;
      checks++; if (obs !== 8'b0000_0000) begin errors++; $display("FAIL mid_reset: obs=%b expected=%b", obs, 8'b0000_0000); end
      @(negedge clk_i);
      reset_n = 1'b1;
      exp_obs = 8'b0000_0101;
      quarter_i = 1'b1; step();
      checks++; if (obs !== exp_obs) begin errors++; $display("FAIL mid_recover: obs=%b expected=%b", obs, exp_obs); end
   endtask

   initial begin
      test_reset();
      test_exact_price();
      test_overpay();
      test_refund();
      test_simultaneous();
      test_timeout();
      test_reset_mid_payout();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
